tl_mem_responder: RTL and testbench

TileLink-UH memory responder that terminates a tile's `tl_master_*` port: it accepts A-channel Get/Put requests, stores data in an internal word-addressed memory and returns D-channel responses. It is the slave end of the tile's outbound TileLink interface. It is used in simulation and formal harnesses around the RVFI-wrapped Rocket tile so that fetches, loads and stores complete without a full uncore. One transaction is in flight at a time.

---
 rtl/tl_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_tl_mem_responder.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_mem_responder.sv
// TileLink-UH memory responder: accepts A-channel Get/Put, stores data in a 64-bit word memory and
// answers on the D channel, one transaction in flight at a time.
module tl_mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned RESP_DELAY = 0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        tl_a_ready,
    input  logic        tl_a_valid,
    input  logic [2:0]  tl_a_bits_opcode,
    input  logic [2:0]  tl_a_bits_param,
    input  logic [3:0]  tl_a_bits_size,
    input  logic        tl_a_bits_source,
    input  logic [31:0] tl_a_bits_address,
    input  logic [7:0]  tl_a_bits_mask,
    input  logic [63:0] tl_a_bits_data,
    input  logic        tl_a_bits_corrupt,
    input  logic        tl_d_ready,
    output logic        tl_d_valid,
    output logic [2:0]  tl_d_bits_opcode,
    output logic [1:0]  tl_d_bits_param,
    output logic [3:0]  tl_d_bits_size,
    output logic        tl_d_bits_source,
    output logic        tl_d_bits_sink,
    output logic        tl_d_bits_denied,
    output logic [63:0] tl_d_bits_data,
    output logic        tl_d_bits_corrupt
);
    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam logic [63:0] MEM_END    = {32'd0, BASE_ADDR} + 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  DELAY_LAST = (RESP_DELAY == 0) ? 4'd0 : 4'(RESP_DELAY - 1);

    typedef enum logic [1:0] {StIdle, StPut, StWait, StResp} state_t;

    logic [63:0]      r_mem [DEPTH];
    state_t           r_state;
    logic             r_is_get;
    logic             r_denied;
    logic             r_source;
    logic [3:0]       r_size;
    logic [3:0]       r_beats;
    logic [3:0]       r_beat;
    logic [3:0]       r_delay;
    logic [IDX_W-1:0] r_idx;

    logic             w_a_fire;
    logic             w_req_put;
    logic             w_req_get;
    logic             w_req_denied;
    logic [3:0]       w_req_beats;
    logic [31:0]      w_offset;
    logic [31:0]      w_align_mask;
    logic [63:0]      w_req_end;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_last;
    logic             w_d_valid;
    state_t           w_after_req;
    logic             w_unused;

    // a_ready depends only on state and reset, never on d_ready
    assign tl_a_ready = ((r_state == StIdle) || (r_state == StPut)) && !reset;
    assign w_a_fire   = tl_a_valid && tl_a_ready;

    assign w_req_put    = (tl_a_bits_opcode == 3'd0) || (tl_a_bits_opcode == 3'd1);
    assign w_req_get    = (tl_a_bits_opcode == 3'd4);
    assign w_offset     = tl_a_bits_address - BASE_ADDR;
    assign w_align_mask = (32'd1 << tl_a_bits_size) - 32'd1;
    assign w_req_end    = {32'd0, tl_a_bits_address} + (64'd1 << tl_a_bits_size);
    assign w_req_denied = !(w_req_put || w_req_get) || (tl_a_bits_size > 4'd6)
                          || ((tl_a_bits_address & w_align_mask) != 32'd0)
                          || (tl_a_bits_address < BASE_ADDR) || (w_req_end > MEM_END);

    always_comb begin
        case (tl_a_bits_size)
            4'd4:    w_req_beats = 4'd2;
            4'd5:    w_req_beats = 4'd4;
            4'd6:    w_req_beats = 4'd8;
            default: w_req_beats = 4'd1;
        endcase
    end

    assign w_last      = (r_beat == r_beats - 4'd1);
    assign w_after_req = (RESP_DELAY > 0) ? StWait : StResp;
    assign w_rd_idx    = r_idx + IDX_W'(r_beat);
    assign w_wr_idx    = (r_state == StIdle) ? w_offset[IDX_W+2:3] : w_rd_idx;
    assign w_wr_en     = w_a_fire && !tl_a_bits_corrupt
                         && ((r_state == StIdle) ? (w_req_put && !w_req_denied) : !r_denied);

    // Memory has no reset so contents survive a mid-transaction reset
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (tl_a_bits_mask[i]) begin
                    r_mem[w_wr_idx][i*8 +: 8] <= tl_a_bits_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= StIdle;
            r_is_get <= 1'b0;
            r_denied <= 1'b0;
            r_source <= 1'b0;
            r_size   <= 4'd0;
            r_beats  <= 4'd0;
            r_beat   <= 4'd0;
            r_delay  <= 4'd0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_a_fire) begin
                        r_is_get <= w_req_get;
                        r_denied <= w_req_denied;
                        r_source <= tl_a_bits_source;
                        r_size   <= tl_a_bits_size;
                        r_beats  <= w_req_beats;
                        r_idx    <= w_offset[IDX_W+2:3];
                        r_delay  <= 4'd0;
                        if (w_req_put && (w_req_beats > 4'd1)) begin
                            r_state <= StPut;
                            r_beat  <= 4'd1;
                        end else begin
                            r_state <= w_after_req;
                            r_beat  <= 4'd0;
                        end
                    end
                end
                StPut: begin
                    if (w_a_fire) begin
                        if (w_last) begin
                            r_state <= w_after_req;
                            r_beat  <= 4'd0;
                        end else begin
                            r_beat <= r_beat + 4'd1;
                        end
                    end
                end
                StWait: begin
                    if (r_delay == DELAY_LAST) begin
                        r_state <= StResp;
                        r_delay <= 4'd0;
                    end else begin
                        r_delay <= r_delay + 4'd1;
                    end
                end
                StResp: begin
                    if (tl_d_ready) begin
                        if (r_is_get && !w_last) begin
                            r_beat <= r_beat + 4'd1;
                        end else begin
                            r_state <= StIdle;
                            r_beat  <= 4'd0;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_d_valid         = (r_state == StResp) && !reset;
    assign tl_d_valid        = w_d_valid;
    assign tl_d_bits_opcode  = {2'b00, w_d_valid && r_is_get};
    assign tl_d_bits_param   = 2'd0;
    assign tl_d_bits_size    = w_d_valid ? r_size : 4'd0;
    assign tl_d_bits_source  = w_d_valid && r_source;
    assign tl_d_bits_sink    = 1'b0;
    assign tl_d_bits_denied  = w_d_valid && r_denied;
    assign tl_d_bits_data    = (w_d_valid && r_is_get && !r_denied) ? r_mem[w_rd_idx] : 64'd0;
    assign tl_d_bits_corrupt = w_d_valid && r_is_get && r_denied;

    assign w_unused = ^{tl_a_bits_param, w_offset};
endmodule

// File: tb/tb_tl_mem_responder.sv
// Bench for tl_mem_responder: directed scenarios plus randomized traffic checked against an
// array-based memory model; a second instance exercises the response delay.
module tb_tl_mem_responder;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 256;
    localparam int          DELAY = 3;

    logic clock = 1'b0;
    logic reset;

    logic        tl_a_ready, tl_a_valid, tl_a_bits_source, tl_a_bits_corrupt;
    logic [2:0]  tl_a_bits_opcode, tl_a_bits_param;
    logic [3:0]  tl_a_bits_size;
    logic [31:0] tl_a_bits_address;
    logic [7:0]  tl_a_bits_mask;
    logic [63:0] tl_a_bits_data;
    logic        tl_d_ready, tl_d_valid, tl_d_bits_source, tl_d_bits_sink;
    logic        tl_d_bits_denied, tl_d_bits_corrupt;
    logic [2:0]  tl_d_bits_opcode;
    logic [1:0]  tl_d_bits_param;
    logic [3:0]  tl_d_bits_size;
    logic [63:0] tl_d_bits_data;

    logic        d2_a_ready, d2_a_valid, d2_a_source, d2_a_corrupt;
    logic [2:0]  d2_a_opcode, d2_a_param;
    logic [3:0]  d2_a_size;
    logic [31:0] d2_a_address;
    logic [7:0]  d2_a_mask;
    logic [63:0] d2_a_data;
    logic        d2_d_ready, d2_d_valid, d2_d_source, d2_d_sink, d2_d_denied, d2_d_corrupt;
    logic [2:0]  d2_d_opcode;
    logic [1:0]  d2_d_param;
    logic [3:0]  d2_d_size;
    logic [63:0] d2_d_data;

    int total = 0;
    int bad   = 0;
    logic [63:0] mdl_mem [DEPTH];

    always #5 clock = ~clock;

    tl_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RESP_DELAY(0)) dut (
        .clock(clock), .reset(reset),
        .tl_a_ready(tl_a_ready), .tl_a_valid(tl_a_valid),
        .tl_a_bits_opcode(tl_a_bits_opcode), .tl_a_bits_param(tl_a_bits_param),
        .tl_a_bits_size(tl_a_bits_size), .tl_a_bits_source(tl_a_bits_source),
        .tl_a_bits_address(tl_a_bits_address), .tl_a_bits_mask(tl_a_bits_mask),
        .tl_a_bits_data(tl_a_bits_data), .tl_a_bits_corrupt(tl_a_bits_corrupt),
        .tl_d_ready(tl_d_ready), .tl_d_valid(tl_d_valid),
        .tl_d_bits_opcode(tl_d_bits_opcode), .tl_d_bits_param(tl_d_bits_param),
        .tl_d_bits_size(tl_d_bits_size), .tl_d_bits_source(tl_d_bits_source),
        .tl_d_bits_sink(tl_d_bits_sink), .tl_d_bits_denied(tl_d_bits_denied),
        .tl_d_bits_data(tl_d_bits_data), .tl_d_bits_corrupt(tl_d_bits_corrupt)
    );

    tl_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RESP_DELAY(DELAY)) dut_d (
        .clock(clock), .reset(reset),
        .tl_a_ready(d2_a_ready), .tl_a_valid(d2_a_valid),
        .tl_a_bits_opcode(d2_a_opcode), .tl_a_bits_param(d2_a_param),
        .tl_a_bits_size(d2_a_size), .tl_a_bits_source(d2_a_source),
        .tl_a_bits_address(d2_a_address), .tl_a_bits_mask(d2_a_mask),
        .tl_a_bits_data(d2_a_data), .tl_a_bits_corrupt(d2_a_corrupt),
        .tl_d_ready(d2_d_ready), .tl_d_valid(d2_d_valid),
        .tl_d_bits_opcode(d2_d_opcode), .tl_d_bits_param(d2_d_param),
        .tl_d_bits_size(d2_d_size), .tl_d_bits_source(d2_d_source),
        .tl_d_bits_sink(d2_d_sink), .tl_d_bits_denied(d2_d_denied),
        .tl_d_bits_data(d2_d_data), .tl_d_bits_corrupt(d2_d_corrupt)
    );

    // Reference model rules
    function automatic bit mdl_denied(input logic [2:0] op, input logic [3:0] size,
                                      input logic [31:0] addr);
        longint a, n, lo, hi;
        a  = {32'd0, addr};
        n  = longint'(1) << size;
        lo = {32'd0, BASE};
        hi = lo + 8 * DEPTH;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
        if (size > 4'd6) return 1'b1;
        if (a % n != 0) return 1'b1;
        if (a < lo || a + n > hi) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int mdl_beats(input logic [3:0] size);
        int s = int'(size);
        return (s > 3) ? (1 << (s - 3)) : 1;
    endfunction

    function automatic int mdl_index(input logic [31:0] addr);
        return int'((addr - BASE) >> 3);
    endfunction

    task automatic mdl_write(input int idx, input logic [7:0] mask, input logic [63:0] data);
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) mdl_mem[idx][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    // Drivers: each starts and ends 1 time unit after a rising edge
    task automatic a_send(input logic [2:0] op, input logic [3:0] size, input logic src,
                          input logic [31:0] addr, input logic [7:0] mask,
                          input logic [63:0] data, input logic cor, output bit ok);
        ok = 1'b0;
        tl_a_valid = 1'b1;  tl_a_bits_opcode = op;    tl_a_bits_param = 3'($urandom);
        tl_a_bits_size = size; tl_a_bits_source = src; tl_a_bits_address = addr;
        tl_a_bits_mask = mask; tl_a_bits_data = data;  tl_a_bits_corrupt = cor;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (tl_a_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        tl_a_valid = 1'b0;
    endtask

    task automatic d_recv(output bit ok, output int lat, output logic [2:0] op,
                          output logic [3:0] size, output logic src, output logic den,
                          output logic [63:0] data, output logic cor);
        ok = 1'b0; lat = 0; op = '0; size = '0; src = 1'b0; den = 1'b0; data = '0; cor = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (tl_d_valid) begin
                ok = 1'b1;
                op = tl_d_bits_opcode; size = tl_d_bits_size; src = tl_d_bits_source;
                den = tl_d_bits_denied; data = tl_d_bits_data; cor = tl_d_bits_corrupt;
                break;
            end
            lat++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; tl_a_valid = 1'b0; tl_d_ready = 1'b1; d2_a_valid = 1'b0; d2_d_ready = 1'b1;
        tl_a_bits_opcode = '0; tl_a_bits_param = '0; tl_a_bits_size = '0; tl_a_bits_source = 0;
        tl_a_bits_address = '0; tl_a_bits_mask = '0; tl_a_bits_data = '0; tl_a_bits_corrupt = 0;
        d2_a_opcode = '0; d2_a_param = '0; d2_a_size = '0; d2_a_source = 1'b0;
        d2_a_address = '0; d2_a_mask = '0; d2_a_data = '0; d2_a_corrupt = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        total++;
        if (tl_a_ready !== 1'b0 || tl_d_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake: a_ready=%b d_valid=%b want 0 0", tl_a_ready,
                     tl_d_valid);
        end
        total++;
        if ({tl_d_bits_opcode, tl_d_bits_param, tl_d_bits_size, tl_d_bits_source,
             tl_d_bits_sink, tl_d_bits_denied, tl_d_bits_data, tl_d_bits_corrupt} !== '0) begin
            bad++;
            $display("FAIL reset_dbits: opcode=%0d size=%0d data=%h want all 0",
                     tl_d_bits_opcode, tl_d_bits_size, tl_d_bits_data);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (tl_a_ready !== 1'b1 || tl_d_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: a_ready=%b d_valid=%b want 1 0", tl_a_ready, tl_d_valid);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic setup_clear();
        bit ok, rok; int lat, nbad; logic [2:0] op; logic [3:0] sz; logic src, den, cor;
        logic [63:0] data;
        nbad = 0;
        for (int w = 0; w < DEPTH; w += 8) begin
            for (int k = 0; k < 8; k++) begin
                a_send(3'd0, 4'd6, 1'b0, BASE + 32'(w * 8), 8'hFF, 64'd0, 1'b0, ok);
                if (!ok) nbad++;
            end
            d_recv(rok, lat, op, sz, src, den, data, cor);
            if (!rok || op !== 3'd0 || den !== 1'b0) nbad++;
        end
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 64'd0;
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL clear_acks: bad_acks=%0d want 0", nbad);
        end
    endtask

    task automatic test_put_get();
        bit ok, rok; int lat; logic [2:0] op; logic [3:0] sz; logic src, den, cor;
        logic [63:0] data;
        a_send(3'd0, 4'd3, 1'b1, BASE, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, ok);
        mdl_write(0, 8'hFF, 64'h0123_4567_89AB_CDEF);
        d_recv(rok, lat, op, sz, src, den, data, cor);
        total++;
        if (!ok || !rok || {op, sz, src, den} !== {3'd0, 4'd3, 1'b1, 1'b0} || lat != 0) begin
            bad++;
            $display("FAIL putfull_ack: op=%0d size=%0d src=%b den=%b lat=%0d want 0 3 1 0 0",
                     op, sz, src, den, lat);
        end
        a_send(3'd4, 4'd3, 1'b1, BASE, 8'hFF, 64'd0, 1'b0, ok);
        d_recv(rok, lat, op, sz, src, den, data, cor);
        total++;
        if (!rok || {op, sz, src, den, cor} !== {3'd1, 4'd3, 1'b1, 1'b0, 1'b0} || lat != 0) begin
            bad++;
            $display("FAIL get_hdr: op=%0d size=%0d src=%b den=%b cor=%b lat=%0d want 1 3 1 0 0 0",
                     op, sz, src, den, cor, lat);
        end
        total++;
        if (data !== 64'h0123_4567_89AB_CDEF) begin
            bad++;
            $display("FAIL get_data: got %h want 0123456789abcdef", data);
        end
        a_send(3'd1, 4'd3, 1'b0, BASE + 32'd8, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, ok);
        mdl_write(1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
        d_recv(rok, lat, op, sz, src, den, data, cor);
        total++;
        if (!rok || op !== 3'd0 || den !== 1'b0 || lat != 0) begin
            bad++;
            $display("FAIL putpartial_ack: op=%0d den=%b lat=%0d want 0 0 0", op, den, lat);
        end
        a_send(3'd4, 4'd3, 1'b0, BASE + 32'd8, 8'hFF, 64'd0, 1'b0, ok);
        d_recv(rok, lat, op, sz, src, den, data, cor);
        total++;
        if (data !== 64'h0000_0000_FFFF_FFFF) begin
            bad++;
            $display("FAIL putpartial_data: got %h want 00000000ffffffff", data);
        end
    endtask

    task automatic test_burst();
        bit ok, rok, stalled; int lat, k, nto; logic [2:0] op; logic [3:0] sz;
        logic src, den, cor; logic [63:0] data; logic [72:0] held, cur;
        nto = 0;
        for (int b = 0; b < 8; b++) begin
            a_send(3'd0, 4'd6, 1'b0, BASE + 32'd128, 8'hFF, 64'(b), 1'b0, ok);
            mdl_write(16 + b, 8'hFF, 64'(b));
            if (!ok) nto++;
        end
        d_recv(rok, lat, op, sz, src, den, data, cor);
        total++;
        if (nto != 0 || !rok || op !== 3'd0 || den !== 1'b0 || lat != 0) begin
            bad++;
            $display("FAIL burst_put_ack: op=%0d den=%b lat=%0d a_timeouts=%0d want 0 0 0 0",
                     op, den, lat, nto);
        end
        a_send(3'd4, 4'd6, 1'b1, BASE + 32'd128, 8'hFF, 64'd0, 1'b0, ok);
        k = 0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 200 && k < 8; c++) begin
            tl_d_ready = 1'($urandom);
            @(negedge clock);
            cur = {tl_d_bits_opcode, tl_d_bits_size, tl_d_bits_source, tl_d_bits_denied,
                   tl_d_bits_data, tl_d_bits_corrupt};
            if (tl_d_valid) begin
                if (stalled) begin
                    total++;
                    if (cur !== held) begin
                        bad++;
                        $display("FAIL stall_hold: beat %0d got %h want %h", k, cur, held);
                    end
                end
                if (tl_d_ready) begin
                    total++;
                    if (tl_d_bits_data !== 64'(k) || tl_d_bits_opcode !== 3'd1) begin
                        bad++;
                        $display("FAIL burst_get_beat: beat %0d data=%h op=%0d want %h 1",
                                 k, tl_d_bits_data, tl_d_bits_opcode, 64'(k));
                    end
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = cur;
                end
            end
            @(posedge clock);
            #1;
        end
        tl_d_ready = 1'b1;
        total++;
        if (k != 8) begin
            bad++;
            $display("FAIL burst_get_count: got %0d beats want 8", k);
        end
    endtask

    task automatic test_denied();
        bit ok, rok; int lat; logic [2:0] op; logic [3:0] sz; logic src, den, cor;
        logic [63:0] data;
        logic [31:0] addrs [3];
        addrs[0] = BASE + 32'(8 * DEPTH);
        addrs[1] = BASE + 32'd4;
        addrs[2] = BASE - 32'd8;
        for (int i = 0; i < 3; i++) begin
            a_send(3'd4, 4'd3, 1'b0, addrs[i], 8'hFF, 64'd0, 1'b0, ok);
            d_recv(rok, lat, op, sz, src, den, data, cor);
            total++;
            if (!rok || {op, den, cor} !== {3'd1, 1'b1, 1'b1} || data !== 64'd0) begin
                bad++;
                $display("FAIL denied_get%0d: op=%0d den=%b cor=%b data=%h want 1 1 1 0",
                         i, op, den, cor, data);
            end
        end
        a_send(3'd4, 4'd6, 1'b0, BASE + 32'd8, 8'hFF, 64'd0, 1'b0, ok);
        for (int b = 0; b < 8; b++) begin
            d_recv(rok, lat, op, sz, src, den, data, cor);
            total++;
            if (!rok || lat != 0 || {op, den, cor} !== {3'd1, 1'b1, 1'b1} || data !== 64'd0) begin
                bad++;
                $display("FAIL denied_burst: beat %0d lat=%0d op=%0d den=%b cor=%b data=%h",
                         b, lat, op, den, cor, data);
            end
        end
        a_send(3'd2, 4'd3, 1'b1, BASE, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, ok);
        d_recv(rok, lat, op, sz, src, den, data, cor);
        total++;
        if (!rok || {op, src, den, cor} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL denied_opcode: op=%0d src=%b den=%b cor=%b want 0 1 1 0",
                     op, src, den, cor);
        end
        a_send(3'd4, 4'd3, 1'b0, BASE, 8'hFF, 64'd0, 1'b0, ok);
        d_recv(rok, lat, op, sz, src, den, data, cor);
        total++;
        if (data !== mdl_mem[0]) begin
            bad++;
            $display("FAIL denied_no_write: got %h want %h", data, mdl_mem[0]);
        end
    endtask

    task automatic test_delay();
        int lat; bit ar_seen;
        logic [3:0] sizes [2];
        logic [2:0] ops [2];
        ops[0] = 3'd0; ops[1] = 3'd4;
        sizes[0] = 4'd3; sizes[1] = 4'd3;
        for (int t = 0; t < 2; t++) begin
            d2_a_valid = 1'b1; d2_a_opcode = ops[t]; d2_a_size = sizes[t]; d2_a_source = 1'b1;
            d2_a_address = BASE + 32'd16; d2_a_mask = 8'hFF; d2_a_data = 64'hDEAD_BEEF_0000_1111;
            d2_a_corrupt = 1'b0;
            for (int i = 0; i < 64; i++) begin
                @(negedge clock);
                if (d2_a_ready) break;
            end
            @(posedge clock);
            #1;
            d2_a_valid = 1'b0;
            lat = 0; ar_seen = 1'b0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clock);
                if (d2_a_ready) ar_seen = 1'b1;
                if (d2_d_valid) break;
                lat++;
            end
            total++;
            if (lat != DELAY || ar_seen) begin
                bad++;
                $display("FAIL delay_latency%0d: lat=%0d a_ready_seen=%b want %0d 0",
                         t, lat, ar_seen, DELAY);
            end
            total++;
            if (d2_d_opcode !== {2'b00, ops[t] == 3'd4} || d2_d_denied !== 1'b0
                || (ops[t] == 3'd4 && d2_d_data !== 64'hDEAD_BEEF_0000_1111)) begin
                bad++;
                $display("FAIL delay_resp%0d: op=%0d den=%b data=%h", t, d2_d_opcode,
                         d2_d_denied, d2_d_data);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_random();
        bit ok, rok, den_e; int lat, nb, ab, db, idx, nto, pick; longint a, n;
        logic [2:0] op, rop; logic [3:0] size, rsz; logic src, rsrc, rden, rcor, cor;
        logic [63:0] data, rdata, exp_data; logic [7:0] mask;
        nto = 0;
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 9);
            op = (pick < 3) ? 3'd0 : (pick < 5) ? 3'd1 : (pick < 9) ? 3'd4
                 : ((($urandom % 2) == 0) ? 3'd2 : 3'd5);
            size = 4'($urandom_range(0, 6));
            src = 1'($urandom);
            n = longint'(1) << size;
            a = {32'd0, BASE} + 8 * longint'($urandom_range(0, DEPTH - 1));
            a = a - (a % n);
            pick = $urandom_range(0, 9);
            if (pick == 7 && size > 0) a = a + 1;
            if (pick == 8) a = {32'd0, BASE} + 8 * DEPTH;
            if (pick == 9) a = {32'd0, BASE} + 8 * DEPTH - n;
            den_e = mdl_denied(op, size, 32'(a));
            nb = mdl_beats(size);
            ab = (op <= 3'd1) ? nb : 1;
            db = (op == 3'd4) ? nb : 1;
            idx = den_e ? 0 : mdl_index(32'(a));
            for (int k = 0; k < ab; k++) begin
                mask = (op == 3'd0) ? 8'hFF : 8'($urandom);
                data = {$urandom, $urandom};
                cor = (($urandom % 8) == 0);
                a_send(op, size, src, 32'(a), mask, data, cor, ok);
                if (!ok) nto++;
                if (op <= 3'd1 && !den_e && !cor) mdl_write(idx + k, mask, data);
            end
            for (int k = 0; k < db; k++) begin
                d_recv(rok, lat, rop, rsz, rsrc, rden, rdata, rcor);
                total++;
                if (!rok || lat != 0 || {rop, rsz, rsrc, rden, rcor}
                    !== {2'b00, op == 3'd4, size, src, den_e, op == 3'd4 && den_e}) begin
                    bad++;
                    $display("FAIL rand_hdr: t=%0d beat=%0d op=%0d size=%0d src=%b den=%b cor=%b lat=%0d; req op=%0d addr=%h",
                             t, k, rop, rsz, rsrc, rden, rcor, lat, op, 32'(a));
                end
                if (op == 3'd4) begin
                    exp_data = den_e ? 64'd0 : mdl_mem[idx + k];
                    total++;
                    if (rdata !== exp_data) begin
                        bad++;
                        $display("FAIL rand_data: t=%0d beat=%0d got %h want %h", t, k, rdata,
                                 exp_data);
                    end
                end
            end
        end
        total++;
        if (nto != 0) begin
            bad++;
            $display("FAIL rand_a_accept: timeouts=%0d want 0", nto);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, rok; int lat; logic [2:0] op; logic [3:0] sz; logic src, den, cor;
        logic [63:0] data;
        a_send(3'd4, 4'd6, 1'b0, BASE + 32'd128, 8'hFF, 64'd0, 1'b0, ok);
        for (int b = 0; b < 4; b++) begin
            d_recv(rok, lat, op, sz, src, den, data, cor);
            total++;
            if (!rok || data !== mdl_mem[16 + b]) begin
                bad++;
                $display("FAIL mid_beat: beat %0d got %h want %h", b, data, mdl_mem[16 + b]);
            end
        end
        reset = 1'b1;
        tl_d_ready = 1'b0;
        @(negedge clock);
        total++;
        if (tl_d_valid !== 1'b0 || tl_a_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: d_valid=%b a_ready=%b want 0 0", tl_d_valid, tl_a_ready);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        tl_d_ready = 1'b1;
        @(negedge clock);
        total++;
        if (tl_d_valid !== 1'b0 || tl_a_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_release: d_valid=%b a_ready=%b want 0 1", tl_d_valid, tl_a_ready);
        end
        @(posedge clock);
        #1;
        a_send(3'd4, 4'd3, 1'b1, BASE + 32'd136, 8'hFF, 64'd0, 1'b0, ok);
        d_recv(rok, lat, op, sz, src, den, data, cor);
        total++;
        if (!ok || !rok || lat != 0 || data !== mdl_mem[17] || {op, src, den} !== {3'd1, 2'b10})
        begin
            bad++;
            $display("FAIL mid_new_get: data=%h op=%0d src=%b den=%b lat=%0d want %h 1 1 0 0",
                     data, op, src, den, lat, mdl_mem[17]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        setup_clear();
        test_put_get();
        test_burst();
        test_denied();
        test_delay();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
